eth_rx_slot_writer: RTL and testbench
=====================================

Name: eth_rx_slot_writer

Overview:
- Upstream write stage for the RX widening buffer (16-bit write side, 11-bit halfword address, per-byte write enables).
- Accepts the MAC's 8-bit AXI-Stream RX bytes and writes each byte into the correct byte lane of the 16-bit port.
- Manages the buffer as a ring of fixed-size frame slots and publishes completed good frames (slot, byte length) to the 64-bit reader side.
- Discards errored, oversize or no-room frames and counts them.

Parameters:
- ADDR_W, 11, halfword address width of the buffer write port.
- SLOTS, 2, number of frame slots; power of two; SLOT_W = log2(SLOTS), minimum 1.
- LEN_W, 12, width of the byte-length field; must hold the slot byte capacity 2^(ADDR_W+1)/SLOTS.

Ports:
- clk_i  in  1  single clock; rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8  RX byte.
- s_axis_tvalid  in  1  byte valid.
- s_axis_tready  out  1  byte accepted when tvalid && tready.
- s_axis_tlast  in  1  last byte of frame.
- s_axis_tuser  in  1  frame error; sampled on the tlast beat only.
- mem_en_o  out  1  buffer write-port enable.
- mem_we_o  out  2  byte-lane write enables.
- mem_addr_o  out  ADDR_W  halfword address.
- mem_din_o  out  16  write data.
- frame_valid_o  out  1  at least one committed frame is pending.
- frame_slot_o  out  SLOT_W  oldest pending slot.
- frame_len_o  out  LEN_W  byte length of the oldest pending frame.
- frame_ack_i  in  1  reader releases the oldest slot.
- slots_used_o  out  SLOT_W+1  committed-slot count.
- drop_cnt_o  out  16  dropped-frame count; wraps at 0xFFFF to 0.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; wr_slot, rd_slot, count and the byte counter all 0.
  - Per-slot length registers 0.
- Slot geometry: CAP = 2^(ADDR_W+1)/SLOTS bytes per slot. Byte k of the frame in slot s goes to halfword (s*CAP/2 + k>>1).
- Lane selection:
  - k even: we = 01.
  - k odd: we = 10.
  - mem_din_o = {byte, byte}.
- Write timing: mem_* are registered. The write appears on the cycle after the accepting beat, with en = 1 for exactly one cycle. en = 0 otherwise.
- State IDLE (tready = 1):
  - The first accepted beat starts a frame.
  - If count < SLOTS: write the byte at k = 0 and go to RECV.
  - If count == SLOTS: go to DROP with no write.
  - If that first beat also has tlast, go directly to COMMIT or to the drop handling below.
- State RECV (tready = 1):
  - Each beat increments k.
  - While k < CAP the byte is written.
  - When k >= CAP the byte is not written and the sticky flag ovf is set.
  - On tlast: if tuser or ovf, drop_cnt++ and go to IDLE. Otherwise go to COMMIT.
- State DROP (tready = 1): no writes. On tlast, drop_cnt++ and go to IDLE.
- State COMMIT (tready = 0, one cycle):
  - len[wr_slot] = k+1 (bytes).
  - wr_slot++ (mod SLOTS), count++.
  - Go to IDLE.
- Reader side:
  - frame_valid_o = (count != 0); frame_slot_o = rd_slot; frame_len_o = len[rd_slot]. All are combinational from registers.
  - frame_ack_i with count != 0: rd_slot++, count--.
  - frame_ack_i with count == 0: ignored.
- Simultaneous COMMIT and ack: count unchanged, both pointers advance.
- Ack frees a slot for the next IDLE start decision only. A frame already in DROP stays dropped.
- Minimum frame is 1 byte (len = 1, we = 01). A frame of exactly CAP bytes is committed with len = CAP.
- Reset mid-frame clears everything. The MAC shares rst_i, so no partial frame follows reset. Any beat in IDLE is treated as a frame start.
- Lengths never exceed CAP. An oversize frame is never committed.

Test Plan:
- 5-byte frame AA..EE, SLOTS = 2, no backpressure -> five single-cycle writes:
  - addr 0, we 01; addr 0, we 10; addr 1, we 01; addr 1, we 10; addr 2, we 01.
  - Then frame_valid = 1, slot 0, len 5, slots_used 1.
- Three 64-byte good frames, no ack -> frames 1 and 2 committed (slots 0, 1; second writes start at addr 1024). Third frame produces no writes; drop_cnt = 1, slots_used = 2.
- 2049-byte frame (CAP = 2048) -> exactly 2048 writes, last at addr 1023 we 10; no commit, drop_cnt = 1. A following 1-byte frame commits with len 1.
- Frame with tuser = 1 on tlast -> bytes written, but no commit, drop_cnt = 1, slot reused by the next good frame at the same base address.
- Commit and frame_ack_i in the same cycle with count = 1 -> count stays 1, rd_slot advances, frame_slot_o shows the new frame, len correct.
- Assert rst_i asynchronously mid-RECV -> all outputs 0 immediately. A subsequent 3-byte frame commits to slot 0 with len 3.

Source files
------------

// File: rtl/eth_rx_slot_writer.sv
// eth_rx_slot_writer: upstream write stage of the RX widening buffer.
// Takes 8-bit AXI-Stream RX bytes from the MAC, steers each byte into the
// correct lane of a 16-bit buffer write port, and manages the buffer as a
// ring of fixed-size frame slots. Good frames are published to the reader
// as (slot, byte length). Errored, oversize or no-room frames are discarded
// and counted.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s_axis_*                8-bit RX byte stream (tuser = error, sampled on tlast)
//   mem_en_o/we_o/addr_o/din_o  registered buffer write port (halfword address)
//   frame_valid_o/slot_o/len_o  oldest committed frame, frame_ack_i releases it
//   slots_used_o            committed-slot count
//   drop_cnt_o              dropped-frame count (wraps)
module eth_rx_slot_writer #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned SLOTS  = 2,
    parameter int unsigned LEN_W  = 12,
    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              mem_en_o,
    output logic [1:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [15:0]       mem_din_o,
    output logic              frame_valid_o,
    output logic [SLOT_W-1:0] frame_slot_o,
    output logic [LEN_W-1:0]  frame_len_o,
    input  logic              frame_ack_i,
    output logic [SLOT_W:0]   slots_used_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int unsigned CAP     = (1 << (ADDR_W + 1)) / SLOTS;
    localparam int unsigned HW_SLOT = (1 << ADDR_W) / SLOTS;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECV   = 2'd1;
    localparam logic [1:0] DROP   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]        state, state_n;
    logic [LEN_W-1:0]  k, k_n;
    logic              ovf, ovf_n;
    logic              wr;
    logic [LEN_W-1:0]  wr_k;
    logic              drop_inc;
    logic              commit;
    logic              beat;
    logic              ack_ok;
    logic [ADDR_W-1:0] addr_c;

    logic [SLOT_W-1:0] wr_slot, rd_slot;
    logic [SLOT_W:0]   count;
    logic [LEN_W-1:0]  len_q [SLOTS];

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        return (s == SLOT_W'(SLOTS - 1)) ? '0 : s + SLOT_W'(1);
    endfunction

    assign beat   = s_axis_tvalid && s_axis_tready;
    assign ack_ok = frame_ack_i && (count != '0);

    // Halfword address of byte wr_k within the slot being filled
    assign addr_c = ADDR_W'(ADDR_W'(wr_slot) * ADDR_W'(HW_SLOT)) + ADDR_W'(wr_k >> 1);

    // Reader view is combinational from registers
    assign frame_valid_o = (count != '0);
    assign frame_slot_o  = rd_slot;
    assign frame_len_o   = len_q[rd_slot];
    assign slots_used_o  = count;

    // Next-state and write decode
    always_comb begin
        state_n  = state;
        k_n      = k;
        ovf_n    = ovf;
        wr       = 1'b0;
        wr_k     = k;
        drop_inc = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (beat) begin
                    k_n   = '0;
                    ovf_n = 1'b0;
                    if (count < (SLOT_W + 1)'(SLOTS)) begin
                        wr   = 1'b1;
                        wr_k = '0;
                        if (s_axis_tlast) begin
                            if (s_axis_tuser) drop_inc = 1'b1;
                            else              state_n  = COMMIT;
                        end else begin
                            state_n = RECV;
                        end
                    end else begin
                        if (s_axis_tlast) drop_inc = 1'b1;
                        else              state_n  = DROP;
                    end
                end
            end
            RECV: begin
                if (beat) begin
                    // k saturates at the last in-slot byte; excess bytes only mark overflow
                    if (k < LEN_W'(CAP - 1)) begin
                        k_n  = k + LEN_W'(1);
                        wr   = 1'b1;
                        wr_k = k + LEN_W'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                    if (s_axis_tlast) begin
                        if (s_axis_tuser || ovf_n) begin
                            drop_inc = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n = COMMIT;
                        end
                    end
                end
            end
            DROP: begin
                if (beat && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_n  = IDLE;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, write port and stream handshake registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            k             <= '0;
            ovf           <= 1'b0;
            s_axis_tready <= 1'b0;
            mem_en_o      <= 1'b0;
            mem_we_o      <= 2'b00;
            mem_addr_o    <= '0;
            mem_din_o     <= '0;
            drop_cnt_o    <= '0;
        end else begin
            state         <= state_n;
            k             <= k_n;
            ovf           <= ovf_n;
            s_axis_tready <= (state_n != COMMIT);
            mem_en_o      <= wr;
            mem_we_o      <= wr ? (wr_k[0] ? 2'b10 : 2'b01) : 2'b00;
            mem_addr_o    <= wr ? addr_c : '0;
            mem_din_o     <= wr ? {s_axis_tdata, s_axis_tdata} : '0;
            if (drop_inc) drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    // Slot ring: write/read pointers, occupancy and per-slot lengths
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_slot <= '0;
            rd_slot <= '0;
            count   <= '0;
            for (int i = 0; i < int'(SLOTS); i++) len_q[i] <= '0;
        end else begin
            if (commit) begin
                len_q[wr_slot] <= k + LEN_W'(1);
                wr_slot        <= next_slot(wr_slot);
            end
            if (ack_ok) rd_slot <= next_slot(rd_slot);
            case ({commit, ack_ok})
                2'b10:   count <= count + (SLOT_W + 1)'(1);
                2'b01:   count <= count - (SLOT_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_slot_writer.sv
// Self-checking bench for eth_rx_slot_writer: directed test-plan scenarios
// plus randomized frames, checked against a frame-level reference model.
module tb_eth_rx_slot_writer;

    localparam int ADDR_W = 11;
    localparam int SLOTS  = 2;
    localparam int LEN_W  = 12;
    localparam int SLOT_W = 1;
    localparam int CAP    = 2048;

    logic              clk, rst;
    logic [7:0]        s_axis_tdata;
    logic              s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic              mem_en_o;
    logic [1:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [15:0]       mem_din_o;
    logic              frame_valid_o;
    logic [SLOT_W-1:0] frame_slot_o;
    logic [LEN_W-1:0]  frame_len_o;
    logic              frame_ack_i;
    logic [SLOT_W:0]   slots_used_o;
    logic [15:0]       drop_cnt_o;

    eth_rx_slot_writer #(.ADDR_W(ADDR_W), .SLOTS(SLOTS), .LEN_W(LEN_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_din_o(mem_din_o),
        .frame_valid_o(frame_valid_o), .frame_slot_o(frame_slot_o),
        .frame_len_o(frame_len_o), .frame_ack_i(frame_ack_i),
        .slots_used_o(slots_used_o), .drop_cnt_o(drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        we;
        logic [15:0]       din;
    } wr_t;
    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic [LEN_W-1:0]  len;
    } fr_t;

    wr_t exp_wr[$];   // expected buffer writes, in order
    fr_t pend[$];     // committed frames not yet acked
    int  m_ws;        // model write slot
    int  m_dc;        // model drop count
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every enabled write must match the next expected one
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst && mem_en_o) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_write", 32'(mem_addr_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr_o), 32'(e.addr));
                check("wr_we",   32'(mem_we_o),   32'(e.we));
                check("wr_din",  32'(mem_din_o),  32'(e.din));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_tready"},  32'(s_axis_tready), 0);
        check({tag, "_en"},      32'(mem_en_o), 0);
        check({tag, "_we"},      32'(mem_we_o), 0);
        check({tag, "_addr"},    32'(mem_addr_o), 0);
        check({tag, "_din"},     32'(mem_din_o), 0);
        check({tag, "_fvalid"},  32'(frame_valid_o), 0);
        check({tag, "_fslot"},   32'(frame_slot_o), 0);
        check({tag, "_flen"},    32'(frame_len_o), 0);
        check({tag, "_used"},    32'(slots_used_o), 0);
        check({tag, "_drops"},   32'(drop_cnt_o), 0);
    endtask

    task automatic check_status();
        check("slots_used", 32'(slots_used_o), 32'(pend.size()));
        check("drop_cnt", 32'(drop_cnt_o), 32'(m_dc));
        check("frame_valid", 32'(frame_valid_o), 32'(pend.size() != 0));
        if (pend.size() != 0) begin
            check("frame_slot", 32'(frame_slot_o), 32'(pend[0].slot));
            check("frame_len", 32'(frame_len_o), 32'(pend[0].len));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pend.delete();
        exp_wr.delete();
        m_ws = 0;
        m_dc = 0;
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit last, input bit user);
        int n;
        s_axis_tdata  = b;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_axis_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) check("tready_timeout", 0, 1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    // Release the oldest frame; with nothing pending the DUT must ignore it
    task automatic do_ack();
        if (pend.size() != 0) begin
            check("ack_fvalid", 32'(frame_valid_o), 1);
            check("ack_slot", 32'(frame_slot_o), 32'(pend[0].slot));
            check("ack_len", 32'(frame_len_o), 32'(pend[0].len));
            void'(pend.pop_front());
        end
        frame_ack_i = 1'b1;
        @(posedge clk); #1;
        frame_ack_i = 1'b0;
    endtask

    // Send a frame; d0 >= 0 gives bytes d0, d0+0x11, ... otherwise random
    task automatic send_frame(input int len, input bit user, input int d0, input bit ack_last);
        bit         full;
        logic [7:0] b;
        full = (pend.size() == SLOTS);
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            b = (d0 >= 0) ? 8'(d0 + 17 * i) : 8'($urandom);
            if (!full && i < CAP)
                exp_wr.push_back(wr_t'{addr: ADDR_W'(m_ws * (CAP / 2) + i / 2),
                                       we:   (i % 2 == 1) ? 2'b10 : 2'b01,
                                       din:  {b, b}});
            send_byte(b, i == len - 1, (i == len - 1) ? user : 1'($urandom_range(1)));
        end
        if (ack_last) do_ack();
        if (full || user || len > CAP) begin
            m_dc = (m_dc + 1) % 65536;
        end else begin
            pend.push_back(fr_t'{slot: SLOT_W'(m_ws), len: LEN_W'(len)});
            m_ws = (m_ws + 1) % SLOTS;
        end
        repeat (3) @(posedge clk); #1;
        check_status();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        frame_ack_i = 1'b0;
        #1;
        check_zero("reset");
        do_reset();

        // 5-byte frame AA..EE
        send_frame(5, 1'b0, 8'hAA, 1'b0);
        check("t5_slot", 32'(frame_slot_o), 0);
        check("t5_len", 32'(frame_len_o), 5);
        check("t5_used", 32'(slots_used_o), 1);
        do_ack();
        check_status();

        // Three 64-byte frames, no ack: third has no room
        do_reset();
        for (int f = 0; f < 3; f++) send_frame(64, 1'b0, -1, 1'b0);
        check("t64_drops", 32'(drop_cnt_o), 1);
        check("t64_used", 32'(slots_used_o), 2);
        do_ack();
        do_ack();
        check_status();

        // Oversize frame, then a 1-byte frame
        do_reset();
        send_frame(CAP + 1, 1'b0, -1, 1'b0);
        check("ovf_drops", 32'(drop_cnt_o), 1);
        check("ovf_used", 32'(slots_used_o), 0);
        send_frame(1, 1'b0, -1, 1'b0);
        check("one_len", 32'(frame_len_o), 1);
        do_ack();

        // Exactly CAP bytes commits
        do_reset();
        send_frame(CAP, 1'b0, -1, 1'b0);
        check("cap_len", 32'(frame_len_o), CAP);
        do_ack();

        // Errored frame, slot reused by next good frame
        do_reset();
        send_frame(10, 1'b1, -1, 1'b0);
        send_frame(7, 1'b0, -1, 1'b0);
        check("reuse_slot", 32'(frame_slot_o), 0);
        check("reuse_drops", 32'(drop_cnt_o), 1);
        do_ack();

        // Commit and ack in the same cycle with one frame pending
        do_reset();
        send_frame(4, 1'b0, -1, 1'b0);
        send_frame(6, 1'b0, -1, 1'b1);
        check("cack_used", 32'(slots_used_o), 1);
        check("cack_slot", 32'(frame_slot_o), 1);
        check("cack_len", 32'(frame_len_o), 6);
        do_ack();
        do_ack();
        check_status();

        // Asynchronous reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            exp_wr.push_back(wr_t'{addr: ADDR_W'(i / 2), we: (i % 2 == 1) ? 2'b10 : 2'b01,
                                   din: {b, b}});
            send_byte(b, 1'b0, 1'b0);
        end
        repeat (2) @(posedge clk); #1;
        s_axis_tvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_zero("midrst");
        check("midrst_pending_writes", 32'(exp_wr.size()), 0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pend.delete(); exp_wr.delete(); m_ws = 0; m_dc = 0;
        send_frame(3, 1'b0, -1, 1'b0);
        check("midrst_slot", 32'(frame_slot_o), 0);
        check("midrst_len", 32'(frame_len_o), 3);
        do_ack();

        // Randomized frames with random acks
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(19) == 0) ? int'($urandom_range(CAP + 1, CAP - 1))
                                            : int'($urandom_range(100, 1));
            send_frame(len, $urandom_range(5) == 0, -1, $urandom_range(4) == 0);
            for (int a = 0; a < int'($urandom_range(2)); a++) begin
                do_ack();
                check_status();
            end
        end

        repeat (4) @(posedge clk); #1;
        check("final_pending_writes", 32'(exp_wr.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
